mem_arbiter: RTL

- Byte-serial controller that owns the single RAM port and shares it between two requesters: instruction fetch (4-byte reads at pc) and the load/store buffer (1/2/4-byte loads and stores).
- Sits between the core front-end/LSB and the RAM.
- Serialises each access into per-byte RAM cycles and assembles little-endian words.
- Arbitrates fairly between requesters and aborts speculative reads on pipeline flush.

---
 rtl/mem_arbiter.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Byte-serial owner of the single RAM port, shared between instruction fetch
// and the load/store buffer; assembles little-endian words from byte reads.
module mem_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              rob_clear_up,
  output logic              ram_rw,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_in,
  input  logic [7:0]        ram_out,
  input  logic              should_fetch,
  input  logic [31:0]       pc,
  output logic              inst_ready,
  output logic [31:0]       inst,
  input  logic              lsb_ready,
  input  logic              work_type,
  input  logic [2:0]        word_size,
  input  logic [31:0]       addr,
  input  logic [31:0]       data_in,
  output logic              data_out_ready,
  output logic [31:0]       data_out
);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  localparam logic FETCH = 1'b0;
  localparam logic LSB   = 1'b1;

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [2:0]        len_q, len_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       buf_q, buf_d;
  logic              is_fetch_q, is_fetch_d;
  logic              last_grant_q, last_grant_d;
  logic              ram_rw_q, ram_rw_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [7:0]        ram_in_q, ram_in_d;
  logic              inst_ready_q, inst_ready_d;
  logic [31:0]       inst_q, inst_d;
  logic              dout_ready_q, dout_ready_d;
  logic [31:0]       dout_q, dout_d;

  // The RAM keeps reading while we are frozen, so remember the byte that was
  // on ram_out when the freeze began and use it on the first thawed edge.
  logic              rdy_prev_q;
  logic [7:0]        held_q;

  logic              fetch_req, lsb_req, grant_lsb;
  logic [2:0]        lsb_len;
  logic [1:0]        byte_idx, next_idx;
  logic [7:0]        cap_byte;
  logic [31:0]       cap_word;

  // A finishing requester is ignored during its own pulse cycle.
  assign fetch_req = should_fetch && !inst_ready_q && !rob_clear_up;
  assign lsb_req   = lsb_ready && !dout_ready_q && (!rob_clear_up || !work_type);
  assign grant_lsb = lsb_req && (!fetch_req || last_grant_q == FETCH);

  assign lsb_len  = (word_size == 3'd0) ? 3'd1 : (word_size == 3'd1) ? 3'd2 : 3'd4;
  assign byte_idx = cnt_q[1:0] - 2'd1;
  assign next_idx = cnt_q[1:0] + 2'd1;

  always_comb begin
    cap_byte = rdy_prev_q ? ram_out : held_q;
    cap_word = buf_q;
    cap_word[{byte_idx, 3'b000} +: 8] = cap_byte;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    len_d        = len_q;
    base_d       = base_q;
    wdata_d      = wdata_q;
    buf_d        = buf_q;
    is_fetch_d   = is_fetch_q;
    last_grant_d = last_grant_q;
    ram_rw_d     = ram_rw_q;
    ram_addr_d   = ram_addr_q;
    ram_in_d     = ram_in_q;
    inst_d       = inst_q;
    dout_d       = dout_q;
    inst_ready_d = 1'b0;
    dout_ready_d = 1'b0;

    case (state_q)
      IDLE: begin
        ram_rw_d = 1'b1;
        if (fetch_req || lsb_req) begin
          cnt_d        = '0;
          buf_d        = '0;
          is_fetch_d   = !grant_lsb;
          last_grant_d = grant_lsb ? LSB : FETCH;
          if (grant_lsb) begin
            base_d     = addr[ADDR_W-1:0];
            len_d      = lsb_len;
            wdata_d    = data_in;
            ram_addr_d = addr[ADDR_W-1:0];
            if (work_type) begin
              state_d = READ;
            end else begin
              state_d  = WRITE;
              ram_rw_d = 1'b0;
              ram_in_d = data_in[7:0];
            end
          end else begin
            base_d     = pc[ADDR_W-1:0];
            len_d      = 3'd4;
            ram_addr_d = pc[ADDR_W-1:0];
            state_d    = READ;
          end
        end
      end

      // cnt_q = k: issue address k+1, capture byte k-1 (one-cycle RAM latency).
      READ: begin
        if (rob_clear_up) begin
          state_d  = IDLE;
          ram_rw_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q != 3'd0) begin
            buf_d = cap_word;
          end
          if (cnt_q + 3'd1 < len_q) begin
            ram_addr_d = base_q + ADDR_W'(cnt_q + 3'd1);
          end
          if (cnt_q == len_q) begin
            state_d = IDLE;
            if (is_fetch_q) begin
              inst_ready_d = 1'b1;
              inst_d       = cap_word;
            end else begin
              dout_ready_d = 1'b1;
              dout_d       = cap_word;
            end
          end
        end
      end

      // Stores are never aborted by a flush.
      WRITE: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q + 3'd1 < len_q) begin
          ram_rw_d   = 1'b0;
          ram_addr_d = base_q + ADDR_W'(cnt_q + 3'd1);
          ram_in_d   = wdata_q[{next_idx, 3'b000} +: 8];
        end else begin
          state_d      = IDLE;
          ram_rw_d     = 1'b1;
          dout_ready_d = 1'b1;
        end
      end

      default: begin
        state_d  = IDLE;
        ram_rw_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      len_q        <= '0;
      base_q       <= '0;
      wdata_q      <= '0;
      buf_q        <= '0;
      is_fetch_q   <= 1'b0;
      last_grant_q <= FETCH;
      ram_rw_q     <= 1'b1;
      ram_addr_q   <= '0;
      ram_in_q     <= '0;
      inst_ready_q <= 1'b0;
      inst_q       <= '0;
      dout_ready_q <= 1'b0;
      dout_q       <= '0;
    end else if (rdy_in) begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      base_q       <= base_d;
      wdata_q      <= wdata_d;
      buf_q        <= buf_d;
      is_fetch_q   <= is_fetch_d;
      last_grant_q <= last_grant_d;
      ram_rw_q     <= ram_rw_d;
      ram_addr_q   <= ram_addr_d;
      ram_in_q     <= ram_in_d;
      inst_ready_q <= inst_ready_d;
      inst_q       <= inst_d;
      dout_ready_q <= dout_ready_d;
      dout_q       <= dout_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      rdy_prev_q <= 1'b1;
      held_q     <= '0;
    end else begin
      rdy_prev_q <= rdy_in;
      if (rdy_prev_q) begin
        held_q <= ram_out;
      end
    end
  end

  assign ram_rw         = ram_rw_q;
  assign ram_addr       = ram_addr_q;
  assign ram_in         = ram_in_q;
  assign inst_ready     = inst_ready_q;
  assign inst           = inst_q;
  assign data_out_ready = dout_ready_q;
  assign data_out       = dout_q;

endmodule
